store_checker: RTL and testbench

- Synthesizable self-checking monitor for the RV32I CPU data-memory bus.
- Watches the CPU's store interface (mem_write, data_adr, write_data) and compares stores against a programmed table of expected (address, data) pairs.
- Stores to a configurable scratch window are ignored.
- Reports pass, mismatch, timeout or configuration error, so CPU program checks can run on the FPGA as well as in simulation.

---
 rtl/store_checker.sv | 216 +++++++++++++++++++++
 tb/tb_store_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// store_checker: watches the CPU store bus during a check run and compares
// each store against a table of expected (address, data) pairs. Stores that
// fall inside the scratch window are only counted. The verdict is PASS,
// mismatch, timeout or configuration error, and it stays latched until the
// next start or reset.
module store_checker #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 24,
    parameter int IGNORE_BASE = 96,
    parameter int IGNORE_SIZE = 4,
    parameter int ORDERED     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           load,
    input  logic [$clog2(DEPTH)-1:0]       load_index,
    input  logic [ADDR_WIDTH-1:0]          load_adr,
    input  logic [DATA_WIDTH-1:0]          load_data,
    input  logic                           start,
    input  logic [$clog2(DEPTH):0]         num_expected,
    input  logic                           mem_write,
    input  logic [ADDR_WIDTH-1:0]          data_adr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [1:0]                     fail_code,
    output logic [ADDR_WIDTH-1:0]          fail_adr,
    output logic [DATA_WIDTH-1:0]          fail_data,
    output logic [$clog2(DEPTH):0]         match_count,
    output logic [7:0]                     ignore_count,
    output logic [$clog2(TIMEOUT+1)-1:0]   cycle_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int NW = IW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    // Window bounds are one bit wider than the address so base+size never wraps.
    localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(IGNORE_BASE);
    localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(IGNORE_BASE)
                                           + (ADDR_WIDTH+1)'(IGNORE_SIZE);
    localparam logic [NW-1:0]       DEPTH_N = NW'(DEPTH);
    localparam logic [CW-1:0]       TO_N    = CW'(TIMEOUT);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_CONFIG   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_tab_adr  [DEPTH];
    logic [DATA_WIDTH-1:0]   r_tab_data [DEPTH];
    logic [DEPTH-1:0]        r_bitmap;
    logic [NW-1:0]           r_num_exp;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [1:0]              r_fail_code;
    logic [ADDR_WIDTH-1:0]   r_fail_adr;
    logic [DATA_WIDTH-1:0]   r_fail_data;
    logic [NW-1:0]           r_match_count;
    logic [7:0]              r_ignore_count;
    logic [CW-1:0]           r_cycle_count;

    logic                    w_in_win;
    logic                    w_cmp;
    logic                    w_ord_hit;
    logic                    w_found;
    logic [IW-1:0]           w_idx;
    logic                    w_hit;
    logic [NW-1:0]           w_mc_inc;
    logic [CW-1:0]           w_cc_inc;
    logic [7:0]              w_ic_sat;

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail_code    = r_fail_code;
    assign fail_adr     = r_fail_adr;
    assign fail_data    = r_fail_data;
    assign match_count  = r_match_count;
    assign ignore_count = r_ignore_count;
    assign cycle_count  = r_cycle_count;

    assign w_in_win  = (IGNORE_SIZE != 0)
                     && ({1'b0, data_adr} >= WIN_LO)
                     && ({1'b0, data_adr} <  WIN_HI);
    assign w_cmp     = mem_write && !w_in_win;
    assign w_ord_hit = (r_tab_adr[r_match_count[IW-1:0]]  == data_adr)
                    && (r_tab_data[r_match_count[IW-1:0]] == write_data);
    assign w_hit     = (ORDERED != 0) ? w_ord_hit : w_found;
    assign w_mc_inc  = r_match_count + NW'(1);
    assign w_cc_inc  = r_cycle_count + CW'(1);
    assign w_ic_sat  = (r_ignore_count == 8'hFF) ? r_ignore_count
                                                 : r_ignore_count + 8'd1;

    // Find the lowest-index unmatched live entry equal to the current store.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((NW'(i) < r_num_exp) && !r_bitmap[i]
                && (r_tab_adr[i] == data_adr) && (r_tab_data[i] == write_data)) begin
                w_found = 1'b1;
                w_idx   = IW'(i);
            end
        end
    end

    // Expected-store table: written only while no run is in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_adr[i]  <= '0;
                r_tab_data[i] <= '0;
            end
        end else if (load && (r_state != S_RUN)) begin
            r_tab_adr[load_index]  <= load_adr;
            r_tab_data[load_index] <= load_data;
        end
    end

    // Run control FSM with registered verdict and counter outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_bitmap       <= '0;
            r_num_exp      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail_code    <= FC_NONE;
            r_fail_adr     <= '0;
            r_fail_data    <= '0;
            r_match_count  <= '0;
            r_ignore_count <= '0;
            r_cycle_count  <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cycle_count <= w_cc_inc;
                    if (mem_write && w_in_win) begin
                        r_ignore_count <= w_ic_sat;
                    end
                    if (w_cmp && !w_hit) begin
                        // A mismatching store outranks every other outcome.
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_MISMATCH;
                        r_fail_adr  <= data_adr;
                        r_fail_data <= write_data;
                    end else begin
                        if (w_cmp) begin
                            r_match_count <= w_mc_inc;
                            if (ORDERED == 0) begin
                                r_bitmap[w_idx] <= 1'b1;
                            end
                        end
                        if (w_cmp && (w_mc_inc == r_num_exp)) begin
                            // Final match wins over a timeout on the same edge.
                            r_state <= S_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else if (w_cc_inc == TO_N) begin
                            r_state     <= S_FAIL;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_fail_code <= FC_TIMEOUT;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        r_num_exp      <= num_expected;
                        r_bitmap       <= '0;
                        r_match_count  <= '0;
                        r_ignore_count <= '0;
                        r_cycle_count  <= '0;
                        r_fail_adr     <= '0;
                        r_fail_data    <= '0;
                        r_pass         <= 1'b0;
                        r_fail_code    <= FC_NONE;
                        if (num_expected == '0) begin
                            r_state <= S_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else if (num_expected > DEPTH_N) begin
                            r_state     <= S_FAIL;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_fail_code <= FC_CONFIG;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: an ordered and an unordered instance share
// one stimulus stream; expected verdicts are queued as each step is driven
// and popped once the instances report done.
module tb_store_checker;

    typedef struct packed {
        logic        done;
        logic        busy;
        logic        pass;
        logic [1:0]  code;
        logic [31:0] adr;
        logic [31:0] data;
        logic [2:0]  mc;
        logic [7:0]  ic;
        logic [4:0]  cc;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  load_index = '0;
    logic [31:0] load_adr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic [2:0]  num_expected = '0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;

    logic        o0_busy, o0_done, o0_pass, o1_busy, o1_done, o1_pass;
    logic [1:0]  o0_code, o1_code;
    logic [31:0] o0_adr, o0_data, o1_adr, o1_data;
    logic [2:0]  o0_mc, o1_mc;
    logic [7:0]  o0_ic, o1_ic;
    logic [4:0]  o0_cc, o1_cc;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb_q[$];

    always #5 clock = ~clock;

    store_checker #(.ORDERED(1)) u0 (
        .clock(clock), .reset(reset), .load(load), .load_index(load_index),
        .load_adr(load_adr), .load_data(load_data), .start(start),
        .num_expected(num_expected), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(o0_busy), .done(o0_done), .pass(o0_pass),
        .fail_code(o0_code), .fail_adr(o0_adr), .fail_data(o0_data),
        .match_count(o0_mc), .ignore_count(o0_ic), .cycle_count(o0_cc)
    );

    store_checker #(.ORDERED(0)) u1 (
        .clock(clock), .reset(reset), .load(load), .load_index(load_index),
        .load_adr(load_adr), .load_data(load_data), .start(start),
        .num_expected(num_expected), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(o1_busy), .done(o1_done), .pass(o1_pass),
        .fail_code(o1_code), .fail_adr(o1_adr), .fail_data(o1_data),
        .match_count(o1_mc), .ignore_count(o1_ic), .cycle_count(o1_cc)
    );

    function automatic res_t mk(input logic d, input logic b, input logic p,
                                input logic [1:0] c, input logic [31:0] a,
                                input logic [31:0] w, input logic [2:0] m,
                                input logic [7:0] i, input logic [4:0] y);
        res_t r;
        r.done = d; r.busy = b; r.pass = p; r.code = c; r.adr = a;
        r.data = w; r.mc = m; r.ic = i; r.cc = y;
        return r;
    endfunction

    function automatic res_t obs(input int d);
        res_t r;
        if (d == 0) r = mk(o0_done, o0_busy, o0_pass, o0_code, o0_adr, o0_data, o0_mc, o0_ic, o0_cc);
        else        r = mk(o1_done, o1_busy, o1_pass, o1_code, o1_adr, o1_data, o1_mc, o1_ic, o1_cc);
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare(input string tag, input int d, input res_t e);
        res_t  o;
        string t;
        o = obs(d);
        t = $sformatf("%s.u%0d", tag, d);
        cmp({t, ".done"}, 32'(o.done), 32'(e.done));
        cmp({t, ".busy"}, 32'(o.busy), 32'(e.busy));
        cmp({t, ".pass"}, 32'(o.pass), 32'(e.pass));
        cmp({t, ".code"}, 32'(o.code), 32'(e.code));
        cmp({t, ".adr"},  o.adr,  e.adr);
        cmp({t, ".data"}, o.data, e.data);
        cmp({t, ".match"}, 32'(o.mc), 32'(e.mc));
        cmp({t, ".ignore"}, 32'(o.ic), 32'(e.ic));
        cmp({t, ".cycles"}, 32'(o.cc), 32'(e.cc));
    endtask

    task automatic push_both(input res_t e0, input res_t e1);
        sb_q.push_back(e0);
        sb_q.push_back(e1);
    endtask

    task automatic check_now(input string tag);
        for (int d = 0; d < 2; d++) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s.sbq observed=empty expected=entry", tag);
            end else begin
                compare(tag, d, sb_q.pop_front());
            end
        end
    endtask

    task automatic verdict(input string tag);
        for (int k = 0; k < 40 && !(o0_done && o1_done); k++) @(negedge clock);
        cmp({tag, ".wait"}, 32'(o0_done && o1_done), 32'd1);
        check_now(tag);
    endtask

    task automatic do_load(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
        load = 1'b1; load_index = i; load_adr = a; load_data = d;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] n);
        start = 1'b1; num_expected = n;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; data_adr = a; write_data = d;
        @(negedge clock);
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        push_both(mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0));
        check_now("reset");
        reset = 1'b1;
        @(negedge clock);

        // Ignored window stores, a load attempted during RUN, then the match.
        do_load(2'd0, 32'd4196, 32'd25);
        do_start(3'd1);
        cmp("t1.busy", 32'(o0_busy), 32'd1);
        load = 1'b1; load_index = 2'd0; load_adr = 32'd1; load_data = 32'd1;
        mem_write = 1'b1; data_adr = 32'd96; write_data = 32'd7;
        @(negedge clock);
        load = 1'b0; mem_write = 1'b0;
        do_store(32'd99, 32'd3);
        push_both(mk(1,0,1,0,0,0,1,2,3), mk(1,0,1,0,0,0,1,2,3));
        do_store(32'd4196, 32'd25);
        cmp("t1.latency", 32'(o0_done), 32'd1);
        verdict("t1");

        // First address past the window is compared and mismatches.
        do_start(3'd1);
        push_both(mk(1,0,0,1,100,25,0,0,1), mk(1,0,0,1,100,25,0,0,1));
        do_store(32'd100, 32'd25);
        cmp("t2.latency", 32'(o0_done), 32'd1);
        verdict("t2");

        // Out-of-order stores: ordered instance fails, unordered passes.
        do_load(2'd0, 32'h10, 32'd1);
        do_load(2'd1, 32'h14, 32'd2);
        do_start(3'd2);
        push_both(mk(1,0,0,1,32'h14,2,0,0,1), mk(1,0,1,0,0,0,2,0,2));
        do_store(32'h14, 32'd2);
        do_store(32'h10, 32'd1);
        verdict("t3");

        // Load and start on the same edge: the run sees the new entry.
        load = 1'b1; load_index = 2'd0; load_adr = 32'h20; load_data = 32'd5;
        start = 1'b1; num_expected = 3'd1;
        @(negedge clock);
        load = 1'b0; start = 1'b0;
        push_both(mk(1,0,1,0,0,0,1,0,1), mk(1,0,1,0,0,0,1,0,1));
        do_store(32'h20, 32'd5);
        verdict("t3b");

        // Repeating an already matched store cannot match it twice.
        do_start(3'd2);
        do_store(32'h20, 32'd5);
        push_both(mk(1,0,0,1,32'h20,5,1,0,2), mk(1,0,0,1,32'h20,5,1,0,2));
        do_store(32'h20, 32'd5);
        verdict("t3c");

        // Timeout with no stores.
        do_start(3'd1);
        repeat (23) @(negedge clock);
        cmp("t4.busy23", 32'(o0_busy), 32'd1);
        cmp("t4.cycles23", 32'(o0_cc), 32'd23);
        push_both(mk(1,0,0,2,0,0,0,0,24), mk(1,0,0,2,0,0,0,0,24));
        verdict("t4");

        // Final matching store on the timeout edge wins.
        do_start(3'd1);
        repeat (23) @(negedge clock);
        push_both(mk(1,0,1,0,0,0,1,0,24), mk(1,0,1,0,0,0,1,0,24));
        do_store(32'h20, 32'd5);
        verdict("t4b");

        // Configuration error and empty run.
        push_both(mk(1,0,0,3,0,0,0,0,0), mk(1,0,0,3,0,0,0,0,0));
        do_start(3'd5);
        cmp("t5.latency", 32'(o0_done), 32'd1);
        verdict("t5");
        push_both(mk(1,0,1,0,0,0,0,0,0), mk(1,0,1,0,0,0,0,0,0));
        do_start(3'd0);
        cmp("t5b.latency", 32'(o0_done), 32'd1);
        verdict("t5b");

        // Reset mid-run clears everything at once, including the table.
        do_load(2'd0, 32'h10, 32'd1);
        do_load(2'd1, 32'h14, 32'd2);
        do_start(3'd2);
        do_store(32'h10, 32'd1);
        cmp("t6.match1", 32'(o0_mc), 32'd1);
        #2 reset = 1'b0;
        #1;
        push_both(mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0));
        check_now("t6.rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_start(3'd1);
        push_both(mk(1,0,0,1,32'h10,1,0,0,1), mk(1,0,0,1,32'h10,1,0,0,1));
        do_store(32'h10, 32'd1);
        verdict("t6.cleared");
        do_load(2'd0, 32'h10, 32'd1);
        do_load(2'd1, 32'h14, 32'd2);
        do_start(3'd2);
        push_both(mk(1,0,1,0,0,0,2,0,2), mk(1,0,1,0,0,0,2,0,2));
        do_store(32'h10, 32'd1);
        do_store(32'h14, 32'd2);
        verdict("t6.rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
